// File: rtl/sram_axi_bridge.sv
// Core-side SRAM-like inst/data ports to a single AXI3 master, one transfer per port in flight.
// Optional BRIDGE_RDATA_BUF_EN registers each R beat before returning it (+1 cycle read latency).
module sram_axi_bridge #(
  parameter logic [3:0] INST_ARID = 4'd0,
  parameter logic [3:0] DATA_ARID = 4'd1,
  parameter logic [3:0] DATA_AWID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  input  logic [1:0]  inst_sram_size,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_BUF} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} wstate_e;

  rstate_e     r_q;
  wstate_e     w_q;
  logic        rd_is_data_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [3:0]  arid_q, wstrb_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [2:0]  arsize_q, awsize_q;
  logic        data_rd_req, data_wr_req, data_busy;
  logic        data_rd_acc, data_wr_acc, inst_rd_acc;
  logic        r_hs, b_hs, rd_ok;
  logic [3:0]  ret_id;
  logic [31:0] ret_data;
  logic        unused_ok;

  assign unused_ok = ^{rresp, rlast, bid, bresp};

  // A single data op may be in flight, read or write, so a read can never overtake a write.
  assign data_rd_req = data_sram_req & ~data_sram_wr;
  assign data_wr_req = data_sram_req & data_sram_wr;
  assign data_busy   = (w_q != W_IDLE) | ((r_q != R_IDLE) & rd_is_data_q);
  assign data_rd_acc = ~reset & data_rd_req & (r_q == R_IDLE) & ~data_busy;
  assign data_wr_acc = ~reset & data_wr_req & ~data_busy;
  assign inst_rd_acc = ~reset & inst_sram_req & (r_q == R_IDLE) & ~data_rd_acc;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc | data_wr_acc;

  assign r_hs = rvalid & rready_q;
  assign b_hs = bvalid & bready_q;

`ifdef BRIDGE_RDATA_BUF_EN
  logic [31:0] buf_data_q;
  logic [3:0]  buf_id_q;
  assign rd_ok    = (r_q == R_BUF) & ~reset;
  assign ret_id   = buf_id_q;
  assign ret_data = buf_data_q;
  always_ff @(posedge clk)
    if (r_hs) begin
      buf_data_q <= rdata;
      buf_id_q   <= rid;
    end
`else
  assign rd_ok    = r_hs & ~reset;
  assign ret_id   = rid;
  assign ret_data = rdata;
`endif

  assign inst_sram_data_ok = rd_ok & (ret_id == INST_ARID);
  assign data_sram_data_ok = (rd_ok & (ret_id != INST_ARID)) | (b_hs & ~reset);
  assign inst_sram_rdata   = ret_data;
  assign data_sram_rdata   = ret_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= R_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rd_is_data_q <= 1'b0;
    end else begin
      case (r_q)
        R_IDLE: if (data_rd_acc | inst_rd_acc) begin
          r_q          <= R_AR;
          arvalid_q    <= 1'b1;
          rd_is_data_q <= data_rd_acc;
          arid_q       <= data_rd_acc ? DATA_ARID : INST_ARID;
          araddr_q     <= data_rd_acc ? data_sram_addr : inst_sram_addr;
          arsize_q     <= {1'b0, data_rd_acc ? data_sram_size : inst_sram_size};
        end
        R_AR: if (arready) begin
          r_q       <= R_R;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        R_R: if (r_hs) begin
          rready_q <= 1'b0;
`ifdef BRIDGE_RDATA_BUF_EN
          r_q      <= R_BUF;
`else
          r_q      <= R_IDLE;
`endif
        end
        default: r_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_q)
        W_IDLE: if (data_wr_acc) begin
          w_q       <= W_AW;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= data_sram_addr;
          awsize_q  <= {1'b0, data_sram_size};
          wdata_q   <= data_sram_wdata;
          wstrb_q   <= data_sram_wstrb;
        end
        W_AW: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((~awvalid_q | awready) & (~wvalid_q | wready)) begin
            w_q      <= W_B;
            bready_q <= 1'b1;
          end
        end
        W_B: if (bvalid) begin
          w_q      <= W_IDLE;
          bready_q <= 1'b0;
        end
        default: w_q <= W_IDLE;
      endcase
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = DATA_AWID;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wid     = DATA_AWID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
endmodule
